r_format_multicycle_cpu: RTL and testbench

Parametrised multi-cycle successor to the single-cycle R-format CPU. It fetches 32-bit MIPS R-format instructions over a request/acknowledge instruction-memory port and executes them through a FETCH/DECODE/EXEC/WB state machine. It holds an internal register file of configurable depth and width, and exposes PC, status, a retired-instruction counter and a debug register read port. It is the top of the Project 2 datapath when instruction memory latency is non-zero.

---
 rtl/r_format_multicycle_cpu.sv | 189 ++++++++++++++++++
 tb/tb_r_format_multicycle_cpu.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/r_format_multicycle_cpu.sv
// Multi-cycle MIPS R-format CPU: FETCH/DECODE/EXEC/WB over a req/ack instruction port.
// Optional R_CPU_SHIFT_EN enables sll/srl; without it those functs retire as NOPs.
module r_format_multicycle_cpu #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic [15:0]       retired,
    input  logic [4:0]        dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);

    localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [5:0] NREGS = 6'(NUM_REGS);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_alu;
    logic              r_wen;
    logic [15:0]       r_retired;
    logic              r_imem_req;
    logic              r_busy;
    logic              r_halted;
    logic [DATA_W-1:0] r_regs [NUM_REGS];

    logic [5:0]        w_op;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [5:0]        w_funct;
    logic [DATA_W-1:0] w_alu;
    logic              w_wen;
    logic              w_unused;

    assign w_op     = r_ir[31:26];
    assign w_rs     = r_ir[25:21];
    assign w_rt     = r_ir[20:16];
    assign w_rd     = r_ir[15:11];
    assign w_funct  = r_ir[5:0];
    assign w_unused = ^r_ir[10:6];

    // Index 0 and indices beyond the implemented file behave as absent registers.
    function automatic logic idx_ok(input logic [4:0] idx);
        return (idx != 5'd0) && ({1'b0, idx} < NREGS);
    endfunction

    function automatic logic [DATA_W-1:0] reg_read(input logic [4:0] idx);
        return idx_ok(idx) ? r_regs[idx[RIDX_W-1:0]] : {DATA_W{1'b0}};
    endfunction

    assign dbg_rdata = reg_read(dbg_raddr);
    assign imem_req  = r_imem_req;
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign busy      = r_busy;
    assign halted    = r_halted;
    assign retired   = r_retired;

`ifdef R_CPU_SHIFT_EN
    localparam int SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    logic [SH_W-1:0] w_shamt;
    assign w_shamt = r_ir[6 +: SH_W];
`endif

    // ALU result and write-enable decoded from funct; unknown functs do not write.
    always_comb begin
        w_alu = {DATA_W{1'b0}};
        w_wen = 1'b0;
        case (w_funct)
            6'h20: begin w_alu = r_a + r_b;      w_wen = 1'b1; end
            6'h22: begin w_alu = r_a - r_b;      w_wen = 1'b1; end
            6'h24: begin w_alu = r_a & r_b;      w_wen = 1'b1; end
            6'h25: begin w_alu = r_a | r_b;      w_wen = 1'b1; end
            6'h27: begin w_alu = ~(r_a | r_b);   w_wen = 1'b1; end
            6'h2A: begin
                w_alu = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
                w_wen = 1'b1;
            end
`ifdef R_CPU_SHIFT_EN
            6'h00: begin w_alu = r_b << w_shamt; w_wen = 1'b1; end
            6'h02: begin w_alu = r_b >> w_shamt; w_wen = 1'b1; end
`endif
            default: begin
                w_alu = {DATA_W{1'b0}};
                w_wen = 1'b0;
            end
        endcase
    end

    // Control FSM with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= {ADDR_W{1'b0}};
            r_ir       <= 32'd0;
            r_a        <= {DATA_W{1'b0}};
            r_b        <= {DATA_W{1'b0}};
            r_alu      <= {DATA_W{1'b0}};
            r_wen      <= 1'b0;
            r_retired  <= 16'd0;
            r_imem_req <= 1'b0;
            r_busy     <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_state    <= S_FETCH;
                        r_pc       <= start_pc;
                        r_imem_req <= 1'b1;
                        r_busy     <= 1'b1;
                        r_halted   <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_ir       <= imem_rdata;
                        r_imem_req <= 1'b0;
                        r_state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_op != 6'd0) begin
                        r_state  <= S_HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_a     <= reg_read(w_rs);
                        r_b     <= reg_read(w_rt);
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_alu   <= w_alu;
                    r_wen   <= w_wen;
                    r_state <= S_WB;
                end
                S_WB: begin
                    r_pc       <= r_pc + PC_STEP;
                    r_retired  <= r_retired + 16'd1;
                    r_imem_req <= 1'b1;
                    r_state    <= S_FETCH;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_imem_req <= 1'b0;
                    r_busy     <= 1'b0;
                    r_halted   <= 1'b0;
                end
            endcase
        end
    end

    // Register file; the write lands on the edge that leaves WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= {DATA_W{1'b0}};
            end
        end else if ((r_state == S_WB) && r_wen && idx_ok(w_rd)) begin
            r_regs[w_rd[RIDX_W-1:0]] <= r_alu;
        end
    end

endmodule

// File: tb/tb_r_format_multicycle_cpu.sv
// Scoreboard bench for r_format_multicycle_cpu: retirements are matched against queued expectations.
module tb_r_format_multicycle_cpu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] start_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] pc;
    logic        busy;
    logic        halted;
    logic [15:0] retired;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;

    r_format_multicycle_cpu #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .pc(pc), .busy(busy), .halted(halted), .retired(retired),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    typedef struct {
        string       tag;
        logic [4:0]  ridx;
        logic [31:0] val;
        logic [31:0] pc;
        int          cyc;
    } sb_t;

    sb_t         sb[$];
    logic [31:0] prog [64];
    logic [31:0] prog_base;
    int          nprog;
    int          ack_delay;
    int          n_checks;
    int          n_errors;
    int          addr_bad;
    logic [31:0] exp_pc;
    int          exp_cyc;
    int          exp_retired;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rinst(input int rs, input int rt, input int rd,
                                          input int sh, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    task automatic emit(input logic [31:0] w);
        prog[nprog] = w;
        nprog++;
    endtask

    task automatic push(input string tag, input int ridx, input logic [31:0] val);
        sb_t e;
        exp_pc += 32'd4;
        e.tag = tag; e.ridx = 5'(ridx); e.val = val; e.pc = exp_pc; e.cyc = exp_cyc;
        sb.push_back(e);
        exp_retired++;
    endtask

    task automatic begin_prog(input logic [31:0] base, input int dly);
        nprog = 0; prog_base = base; ack_delay = dly;
        exp_pc = base; exp_cyc = dly + 4;
    endtask

    // Instruction memory: ack after ack_delay wait cycles, one-cycle ack pulse.
    initial begin
        int wcnt;
        imem_ack = 1'b0; imem_rdata = 32'd0; wcnt = 0;
        forever begin
            @(negedge clk);
            if (imem_ack) begin
                imem_ack = 1'b0; wcnt = 0;
            end else if (imem_req) begin
                if (wcnt >= ack_delay) begin
                    logic [31:0] off;
                    off = (imem_addr - prog_base) >> 2;
                    imem_ack = 1'b1;
                    imem_rdata = prog[off[5:0]];
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic run_prog();
        int          cnt;
        logic [15:0] prev;
        bit          done;
        sb_t         e;
        @(negedge clk); start_pc = prog_base; start = 1'b1;
        @(negedge clk); start = 1'b0; cnt = 0; prev = retired; done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            cnt++;
            if (imem_req && (imem_addr !== pc)) addr_bad++;
            if (retired != prev) begin
                prev = retired;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    dbg_raddr = e.ridx;
                    #1;
                    chk({e.tag, "_val"}, dbg_rdata, e.val);
                    chk({e.tag, "_pc"}, pc, e.pc);
                    chk({e.tag, "_cyc"}, 32'(cnt), 32'(e.cyc));
                end
                cnt = 0;
            end else if (halted) begin
                chk("halt_lat", 32'(cnt), 32'(ack_delay + 2));
                done = 1'b1;
            end
        end
        if (!done) chk("timeout", 32'd0, 32'd1);
        chk("halt_pc", pc, exp_pc);
        chk("halt_retired", 32'(retired), 32'(exp_retired));
        chk("halt_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; addr_bad = 0; exp_retired = 0;
        rst = 1'b1; start = 1'b0; start_pc = 32'd0; dbg_raddr = 5'd0;
        prog_base = 32'd0; ack_delay = 0; nprog = 0;
        for (int i = 0; i < 64; i++) prog[i] = 32'hFC00_0000;
        #2;
        chk("rst_pc", pc, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // add r0,r0,r0 then halt, immediate ack
        begin_prog(32'h100, 0);
        emit(32'h0000_0020);
        emit(32'hFC00_0000);
        push("add_r0", 0, 32'd0);
        run_prog();
        chk("halted_a", 32'(halted), 32'd1);

        // arithmetic chain from r0 with a 3-cycle ack delay
        begin_prog(32'h200, 3);
        emit(rinst(0, 0, 1, 0, 'h27)); push("nor_r1", 1, 32'hFFFF_FFFF);
        emit(rinst(0, 1, 2, 0, 'h22)); push("sub_r2", 2, 32'd1);
        emit(rinst(1, 2, 3, 0, 'h20)); push("add_r3", 3, 32'd0);
        emit(rinst(2, 2, 6, 0, 'h20)); push("add_r6", 6, 32'd2);
        emit(rinst(1, 2, 4, 0, 'h2A)); push("slt_r4", 4, 32'd1);
        emit(rinst(1, 2, 7, 0, 'h24)); push("and_r7", 7, 32'd1);
        emit(rinst(2, 6, 8, 0, 'h25)); push("or_r8", 8, 32'd3);
        emit(32'hFC00_0000);
        run_prog();

        // dropped writes, unknown funct, shifts
        begin_prog(32'h300, 1);
        emit(rinst(1, 1, 0, 0, 'h20));  push("wr_r0", 0, 32'd0);
        emit(rinst(1, 1, 20, 0, 'h20)); push("wr_r20", 20, 32'd0);
        emit(rinst(1, 1, 1, 0, 'h3F));  push("nop_3f", 1, 32'hFFFF_FFFF);
`ifdef R_CPU_SHIFT_EN
        emit(rinst(0, 2, 5, 4, 'h00));  push("sll_r5", 5, 32'h10);
        emit(rinst(0, 1, 10, 28, 'h02)); push("srl_r10", 10, 32'hF);
`else
        emit(rinst(0, 2, 5, 4, 'h00));  push("sll_r5", 5, 32'd0);
        emit(rinst(0, 1, 10, 28, 'h02)); push("srl_r10", 10, 32'd0);
`endif
        emit(32'hFC00_0000);
        run_prog();
        dbg_raddr = 5'd4; #1;
        chk("r4_intact", dbg_rdata, 32'd1);

        // reset asserted while add r3,r1,r1 is in EXEC
        begin_prog(32'h400, 0);
        emit(rinst(1, 1, 3, 0, 'h20));
        emit(32'hFC00_0000);
        @(negedge clk); start_pc = prog_base; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("exec_busy", 32'(busy), 32'd1);
        rst = 1'b1; dbg_raddr = 5'd3; #1;
        chk("mid_r3", dbg_rdata, 32'd0);
        chk("mid_pc", pc, 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_halted", 32'(halted), 32'd0);
        chk("mid_retired", 32'(retired), 32'd0);
        chk("mid_req", 32'(imem_req), 32'd0);
        dbg_raddr = 5'd1; #1;
        chk("mid_r1", dbg_rdata, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("post_rst_idle", 32'(busy), 32'd0);
        chk("post_rst_pc", pc, 32'd0);

        chk("imem_addr_eq_pc", 32'(addr_bad), 32'd0);
        chk("sb_left", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
